// File: rtl/hc595_sipo_latch.sv
// rtl/hc595_sipo_latch.sv - serial-in parallel-out shift register with storage latch and output enable
// Shift register fills MSB-first on srclk; rclk copies it into the storage register driving Q.
module hc595_sipo_latch #(
    parameter int WIDTH = 8
) (
    input  logic             srclk,
    input  logic             srclr_n,
    input  logic             ser,
    input  logic             rclk,
    input  logic             oe_n,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] st;
    logic [WIDTH-1:0] sr_d;
    logic [WIDTH-1:0] st_d;

    // The latch samples sr before this edge's shift, so a same-edge strobe sees the completed byte.
    always_comb begin
        sr_d = {sr[WIDTH-2:0], ser};
        st_d = rclk ? sr : st;
    end

    always_ff @(posedge srclk or negedge srclr_n) begin
        if (!srclr_n) begin
            sr <= '0;
            st <= '0;
        end else begin
            sr <= sr_d;
            st <= st_d;
        end
    end

    assign Q = oe_n ? '0 : st;

endmodule

// File: tb/tb_hc595_sipo_latch.sv
// tb/tb_hc595_sipo_latch.sv - scoreboard bench for hc595_sipo_latch
module tb_hc595_sipo_latch;

    localparam int WIDTH = 8;

    logic             srclk;
    logic             srclr_n;
    logic             ser;
    logic             rclk;
    logic             oe_n;
    logic [WIDTH-1:0] Q;

    hc595_sipo_latch #(.WIDTH(WIDTH)) u_hc595 (
        .srclk   (srclk),
        .srclr_n (srclr_n),
        .ser     (ser),
        .rclk    (rclk),
        .oe_n    (oe_n),
        .Q       (Q)
    );

    initial srclk = 1'b0;
    always #5 srclk = ~srclk;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] exp;
        bit               is_sr;
    } exp_t;

    exp_t sb[$];
    event sample_ev;
    int   tests = 0;
    int   fails = 0;

    // Reference model: the shift register is simply the last WIDTH bits accepted since reset.
    bit               hist[$];
    logic [WIDTH-1:0] st_m;

    function automatic logic [WIDTH-1:0] sr_model();
        logic [WIDTH-1:0] v;
        v = '0;
        foreach (hist[i]) v = {v[WIDTH-2:0], hist[i]};
        return v;
    endfunction

    always begin
        exp_t             e;
        logic [WIDTH-1:0] act;
        @(sample_ev);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = e.is_sr ? u_hc595.sr : Q;
            tests++;
            if (act !== e.exp) begin
                fails++;
                $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
            end
        end
    end

    task automatic clk_edge(input bit b, input bit r);
        @(negedge srclk);
        ser  = b;
        rclk = r;
        @(posedge srclk);
        if (srclr_n) begin
            if (r) st_m = sr_model();
            hist.push_back(b);
            if (hist.size() > WIDTH) void'(hist.pop_front());
        end
        #1 rclk = 1'b0;
    endtask

    task automatic shift_byte(input logic [WIDTH-1:0] b);
        for (int i = WIDTH - 1; i >= 0; i--) clk_edge(b[i], 1'b0);
    endtask

    task automatic latch_only();
        clk_edge(1'($urandom_range(0, 1)), 1'b1);
    endtask

    task automatic check(input string n, input bit is_sr);
        exp_t e;
        #1;
        e.name  = n;
        e.is_sr = is_sr;
        e.exp   = is_sr ? sr_model() : (oe_n ? '0 : st_m);
        sb.push_back(e);
        -> sample_ev;
        #1;
    endtask

    task automatic assert_reset();
        #2;
        srclr_n = 1'b0;
        hist.delete();
        st_m = '0;
    endtask

    task automatic release_reset();
        @(negedge srclk);
        srclr_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] pats[5];
        logic [WIDTH-1:0] rb;
        pats = '{8'b00000001, 8'b10000000, 8'b10101010, 8'b11111111, 8'b00000000};
        srclr_n = 1'b0;
        ser     = 1'b0;
        rclk    = 1'b0;
        oe_n    = 1'b1;
        hist.delete();
        st_m    = '0;

        // Reset state; ser/rclk activity while in reset must be ignored
        clk_edge(1'b1, 1'b1);
        clk_edge(1'b1, 1'b1);
        check("reset_q_oe1", 0);
        check("reset_sr", 1);
        oe_n = 1'b0;
        check("reset_q_oe0", 0);
        release_reset();

        // Reset tests
        shift_byte(8'b10101010);
        latch_only();
        check("rst_pre_q", 0);
        assert_reset();
        check("rst_async_sr", 1);
        check("rst_async_q", 0);
        release_reset();
        shift_byte(8'b11001100);
        assert_reset();
        clk_edge(1'b1, 1'b1);
        check("rst_midshift_q", 0);
        check("rst_midshift_sr", 1);
        release_reset();

        // Basic shift
        shift_byte(8'b10010110);
        check("basic1_sr", 1);
        latch_only();
        check("basic1_q", 0);
        shift_byte(8'b01101001);
        latch_only();
        check("basic2_q", 0);

        // Output enable
        shift_byte(8'b11110000);
        latch_only();
        check("oe_on_q", 0);
        oe_n = 1'b1;
        check("oe_off_q", 0);
        oe_n = 1'b0;
        check("oe_on_again_q", 0);

        // Patterns
        foreach (pats[i]) begin
            shift_byte(pats[i]);
            latch_only();
            check($sformatf("pattern_%0d_q", i), 0);
        end

        // Same-edge latch and shift with ser=1
        shift_byte(8'b00110101);
        clk_edge(1'b1, 1'b1);
        check("same_edge_q", 0);
        check("same_edge_sr", 1);

        // rclk held high over several edges latches each time
        shift_byte(8'b10110010);
        clk_edge(1'b0, 1'b1);
        clk_edge(1'b1, 1'b1);
        clk_edge(1'b1, 1'b1);
        check("rclk_held_q", 0);

        // Random bytes
        for (int k = 0; k < 5; k++) begin
            rb = WIDTH'($urandom);
            shift_byte(rb);
            latch_only();
            check($sformatf("random_%0d_q", k), 0);
        end

        #5;
        if (sb.size() > 0) begin
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
            tests++;
            fails++;
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
